// File: rtl/hamming_dec_engine.sv
// rtl/hamming_dec_engine.sv - SEC-DED Hamming(16,11) block decoder, memory-to-memory
module hamming_dec_engine #(
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam logic [7:0] SRC_B = 8'(SRC_BASE);
    localparam logic [7:0] DST_B = 8'(DST_BASE);
    localparam logic [6:0] LAST  = 7'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_DECODE, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [10:0] data_q, data_d;
    logic [1:0]  flags_q, flags_d;
    logic        done_q, done_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [15:0] w, wc;
    logic [3:0]  syn;
    logic        par;
    logic [1:0]  flags_c;
    logic [10:0] data_c;
    logic [7:0]  src_off, src_nx_off, dst_off;

    // Syndrome, overall parity, single-bit correction and data extraction
    always_comb begin
        w      = {hi_q, lo_q};
        syn[3] = ^w[15:8];
        syn[2] = ^{w[15:12], w[7:4]};
        syn[1] = ^{w[15], w[14], w[11], w[10], w[7], w[6], w[3], w[2]};
        syn[0] = ^{w[15], w[13], w[11], w[9], w[7], w[5], w[3], w[1]};
        par    = ^w;
        wc     = w;
        if (par) begin
            flags_c = 2'b01;
            // syn==0 means p0 itself flipped; flipping w[0] leaves the data alone
            wc[syn] = ~w[syn];
        end else if (syn != 4'd0) begin
            flags_c = 2'b10;
        end else begin
            flags_c = 2'b00;
        end
        data_c = {wc[15:9], wc[7:5], wc[3]};
    end

    // Byte offsets of the current and following word (8-bit, wrapping)
    always_comb begin
        src_off    = SRC_B + {idx_q, 1'b0};
        src_nx_off = SRC_B + {idx_q + 7'd1, 1'b0};
        dst_off    = DST_B + {idx_q, 1'b0};
    end

    // Next-state logic; memory outputs are precomputed for the state being entered
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        data_d    = data_q;
        flags_d   = flags_q;
        done_d    = done_q;
        addr_d    = 8'd0;
        wr_en_d   = 1'b0;
        wr_data_d = 8'd0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RD_LO;
                    idx_d   = 7'd0;
                    done_d  = 1'b0;
                    addr_d  = SRC_B;
                end
            end
            S_RD_LO: begin
                lo_d    = mem_rd_data;
                state_d = S_RD_HI;
                addr_d  = src_off + 8'd1;
            end
            S_RD_HI: begin
                hi_d    = mem_rd_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                data_d    = data_c;
                flags_d   = flags_c;
                state_d   = S_WR_LO;
                addr_d    = dst_off;
                wr_en_d   = 1'b1;
                wr_data_d = data_c[7:0];
            end
            S_WR_LO: begin
                state_d   = S_WR_HI;
                addr_d    = dst_off + 8'd1;
                wr_en_d   = 1'b1;
                wr_data_d = {flags_q, 3'b000, data_q[10:8]};
            end
            S_WR_HI: begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RD_LO;
                    idx_d   = idx_q + 7'd1;
                    addr_d  = src_nx_off;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 7'd0;
            lo_q      <= 8'd0;
            hi_q      <= 8'd0;
            data_q    <= 11'd0;
            flags_q   <= 2'b00;
            done_q    <= 1'b0;
            addr_q    <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            data_q    <= data_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign done        = done_q;
    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule
